// File: rtl/weight_pkg.sv
// weight_pkg: shared constants, types and tables for the weight decoder.
//   XW           - width of an emitted word (7)
//   YW           - width of a requested weight (3)
//   IDXW         - width of the ordinal of a word inside its sequence (6)
//   state_e      - decoder FSM state (IDLE, EMIT)
//   WEIGHT_COUNT - sequence length C(7,y) for every weight y
package weight_pkg;

  localparam int XW   = 7;
  localparam int YW   = 3;
  localparam int IDXW = 6;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam int WEIGHT_COUNT [0:7] = '{1, 7, 21, 35, 35, 21, 7, 1};

endpackage

// File: rtl/next_weight_word.sv
// next_weight_word: combinational same-popcount successor of a 7-bit word.
//   x_i         in   current word
//   y_i         in   latched weight (popcount of x_i)
//   next_x_o    out  smallest 7-bit value above x_i with the same popcount
//   is_last_o   out  next_x_o is the final (largest) word of weight y_i
// Only meaningful when x_i is not already the final word of its weight.
module next_weight_word
  import weight_pkg::*;
(
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  output logic [XW-1:0] next_x_o,
  output logic          is_last_o
);

  logic [XW:0] x8;
  logic [XW:0] low_bit;
  logic [XW:0] ripple;
  logic [XW:0] next8;
  logic [XW:0] last8;
  logic [2:0]  tz;

  // Gosper's hack in 8 bits: isolate the lowest set bit, ripple it up, then
  // re-pack the displaced ones at the bottom of the word.
  assign x8      = {1'b0, x_i};
  assign low_bit = x8 & (~x8 + 8'd1);
  assign ripple  = x8 + low_bit;

  // Count trailing zeros of the isolated bit (scan high to low so the lowest
  // set bit wins; low_bit has at most one bit set anyway).
  always_comb begin
    tz = 3'd0;
    for (int i = XW; i >= 0; i--) begin
      if (low_bit[i]) tz = 3'(i);
    end
  end

  assign next8 = (((ripple ^ x8) >> 2) >> tz) | ripple;

  // Largest word of weight y: y ones packed against the top of the 7 bits.
  assign last8 = ((8'd1 << y_i) - 8'd1) << (3'd7 - y_i);

  assign next_x_o  = next8[XW-1:0];
  assign is_last_o = (next8 == last8);

endmodule

// File: rtl/weight_decoder.sv
// weight_decoder: accepts a weight y (0..7) and emits, in ascending order,
// every 7-bit word whose popcount equals y, one word per handshake.
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   y_valid    in   weight request valid
//   y_ready    out  decoder idle and able to take a weight
//   y          in   requested weight
//   x_valid    out  x holds a valid word
//   x_ready    in   consumer accepts x
//   x          out  current word
//   x_last     out  x is the final word of the sequence
//   x_index    out  ordinal of x within the sequence
//   state_dbg  out  current FSM state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and all outputs come straight
// from registers (y_ready/x_valid are decodes of the state register).
module weight_decoder
  import weight_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            y_valid,
  output logic            y_ready,
  input  logic [YW-1:0]   y,
  output logic            x_valid,
  input  logic            x_ready,
  output logic [XW-1:0]   x,
  output logic            x_last,
  output logic [IDXW-1:0] x_index,
  output state_e          state_dbg
);

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            last_q, last_d;

  logic [XW-1:0]   succ_x;
  logic            succ_is_last;

  next_weight_word u_next (
    .x_i       (x_q),
    .y_i       (y_q),
    .next_x_o  (succ_x),
    .is_last_o (succ_is_last)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (y_valid) begin
          state_d = EMIT;
          y_d     = y;
          // Lowest word of weight y: y ones at the bottom (0 for y=0).
          x_d     = ~(7'h7f << y);
          idx_d   = '0;
          // Only the all-zeros and all-ones weights have a single word.
          last_d  = (y == 3'd0) || (y == 3'd7);
        end
      end
      EMIT: begin
        if (x_ready) begin
          if (last_q) begin
            state_d = IDLE;
            x_d     = '0;
            idx_d   = '0;
            last_d  = 1'b0;
          end else begin
            x_d     = succ_x;
            idx_d   = idx_q + 6'd1;
            last_d  = succ_is_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign y_ready   = (state_q == IDLE);
  assign x_valid   = (state_q == EMIT);
  assign x         = x_q;
  assign x_last    = last_q;
  assign x_index   = idx_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_weight_decoder.sv
module tb_weight_decoder;
  import weight_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       y_valid;
  logic       y_ready;
  logic [2:0] y;
  logic       x_valid;
  logic       x_ready;
  logic [6:0] x;
  logic       x_last;
  logic [5:0] x_index;
  state_e     state_dbg;

  always #5 clk = ~clk;

  weight_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .y         (y),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .x         (x),
    .x_last    (x_last),
    .x_index   (x_index),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model / scoreboard ----------------
  logic [6:0] exp_q[$];
  logic [6:0] got_x[$];
  logic [5:0] got_idx[$];
  logic       got_last[$];
  int         stall_breaks;
  int         ready_in_emit;
  int         bubbles;
  int         collect_cycles;
  bit         timed_out;

  // All 7-bit words with popcount w, ascending: a direct enumeration.
  task automatic build_model(input int w);
    exp_q.delete();
    for (int v = 0; v < 128; v++) begin
      logic [6:0] vv;
      vv = 7'(v);
      if ($countones(vv) == w) exp_q.push_back(vv);
    end
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_weight(input logic [2:0] w);
    int n;
    n = 0;
    y = w;
    y_valid = 1'b1;
    while (!y_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!y_ready) begin
      n_fail++;
      $display("FAIL send_weight_timeout: y_ready=%0b required 1", y_ready);
    end
    @(negedge clk);
    y_valid = 1'b0;
  endtask

  // Consumes words until x_last is taken or max_hs words were taken.
  task automatic collect(input int stall_pct, input bit poke, input int max_hs);
    int         cyc;
    bit         done;
    bit         prev_stall;
    logic [6:0] px;
    logic [5:0] pi;
    cyc = 0; done = 0; prev_stall = 0; px = '0; pi = '0;
    got_x.delete(); got_idx.delete(); got_last.delete();
    stall_breaks = 0; ready_in_emit = 0; bubbles = 0; timed_out = 0;
    while (!done && cyc < 3000) begin
      if (prev_stall && (x !== px || x_index !== pi)) stall_breaks++;
      if (!x_valid) bubbles++;
      if (x_valid && y_ready) ready_in_emit++;
      x_ready = ($urandom_range(99) >= 32'(stall_pct));
      if (poke) begin
        y_valid = 1'($urandom_range(1));
        y       = 3'($urandom_range(7));
      end
      if (x_valid && x_ready) begin
        got_x.push_back(x);
        got_idx.push_back(x_index);
        got_last.push_back(x_last);
        if (x_last || got_x.size() == max_hs) done = 1;
      end
      prev_stall = x_valid && !x_ready;
      px = x;
      pi = x_index;
      @(negedge clk);
      cyc++;
    end
    x_ready = 1'b0;
    y_valid = 1'b0;
    collect_cycles = cyc;
    if (!done) timed_out = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (y_ready !== 1'b1 || x_valid !== 1'b0 || x !== 7'd0 || x_last !== 1'b0 ||
        x_index !== 6'd0 || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_values: y_ready=%0b x_valid=%0b x=%b last=%0b idx=%0d required 1 0 0000000 0 0",
               y_ready, x_valid, x, x_last, x_index);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Full sequence for weight w, compared word by word with the model.
  task automatic test_sequence(input int w, input int stall_pct, input bit poke);
    int cnt;
    build_model(w);
    send_weight(3'(w));
    collect(stall_pct, poke, 100);
    cnt = WEIGHT_COUNT[w];
    n_checks++;
    if (timed_out) begin
      n_fail++;
      $display("FAIL seq_timeout y=%0d: words=%0d required %0d", w, got_x.size(), cnt);
    end
    n_checks++;
    if (got_x.size() != cnt || exp_q.size() != cnt) begin
      n_fail++;
      $display("FAIL seq_length y=%0d: got=%0d required %0d", w, got_x.size(), cnt);
    end
    for (int i = 0; i < got_x.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_x[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL seq_word y=%0d i=%0d: x=%b required %b", w, i, got_x[i], exp_q[i]);
      end
      n_checks++;
      if (got_idx[i] !== 6'(i)) begin
        n_fail++;
        $display("FAIL seq_index y=%0d i=%0d: x_index=%0d required %0d", w, i, got_idx[i], i);
      end
      n_checks++;
      if (got_last[i] !== (i == cnt - 1)) begin
        n_fail++;
        $display("FAIL seq_last y=%0d i=%0d: x_last=%0b required %0b", w, i, got_last[i], (i == cnt - 1));
      end
      n_checks++;
      if ($countones(got_x[i]) != w) begin
        n_fail++;
        $display("FAIL seq_encode y=%0d i=%0d: popcount=%0d required %0d", w, i, $countones(got_x[i]), w);
      end
    end
    n_checks++;
    if (stall_breaks != 0 || bubbles != 0 || ready_in_emit != 0) begin
      n_fail++;
      $display("FAIL seq_handshake y=%0d: stall_breaks=%0d bubbles=%0d ready_in_emit=%0d required 0 0 0",
               w, stall_breaks, bubbles, ready_in_emit);
    end
    if (stall_pct == 0) begin
      n_checks++;
      if (collect_cycles != cnt) begin
        n_fail++;
        $display("FAIL seq_throughput y=%0d: cycles=%0d required %0d", w, collect_cycles, cnt);
      end
    end
    n_checks++;
    if (y_ready !== 1'b1 || x_valid !== 1'b0 || x !== 7'd0 || x_index !== 6'd0 || x_last !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_return_idle y=%0d: y_ready=%0b x_valid=%0b x=%b idx=%0d last=%0b required 1 0 0000000 0 0",
               w, y_ready, x_valid, x, x_index, x_last);
    end
  endtask

  task automatic test_back_to_back();
    send_weight(3'd7);
    n_checks++;
    if (x_valid !== 1'b1 || x !== 7'h7f || x_last !== 1'b1 || x_index !== 6'd0) begin
      n_fail++;
      $display("FAIL b2b_single: valid=%0b x=%b last=%0b idx=%0d required 1 1111111 1 0",
               x_valid, x, x_last, x_index);
    end
    // Final handshake and a new request presented in the same cycle.
    x_ready = 1'b1;
    y_valid = 1'b1;
    y       = 3'd2;
    @(negedge clk);
    n_checks++;
    if (y_ready !== 1'b1 || x_valid !== 1'b0 || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: y_ready=%0b x_valid=%0b required 1 0", y_ready, x_valid);
    end
    @(negedge clk);
    y_valid = 1'b0;
    n_checks++;
    if (x_valid !== 1'b1 || x !== 7'b0000011 || x_index !== 6'd0) begin
      n_fail++;
      $display("FAIL b2b_accept: valid=%0b x=%b idx=%0d required 1 0000011 0", x_valid, x, x_index);
    end
    build_model(2);
    collect(0, 0, 100);
    n_checks++;
    if (timed_out || got_x.size() != 21 || got_x[0] !== exp_q[0] || got_x[20] !== exp_q[20]) begin
      n_fail++;
      $display("FAIL b2b_follow_seq: words=%0d timeout=%0b required 21 0", got_x.size(), timed_out);
    end
  endtask

  task automatic test_reset_mid();
    build_model(4);
    send_weight(3'd4);
    collect(0, 0, 5);
    n_checks++;
    if (got_x.size() != 5 || got_x[4] !== exp_q[4]) begin
      n_fail++;
      $display("FAIL mid_prefix: words=%0d required 5", got_x.size());
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (x_valid !== 1'b0 || y_ready !== 1'b1 || x !== 7'd0 || x_index !== 6'd0 || x_last !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: x_valid=%0b y_ready=%0b x=%b idx=%0d required 0 1 0000000 0",
               x_valid, y_ready, x, x_index);
    end
    @(negedge clk);
    n_checks++;
    if (x_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_resume: x_valid=%0b required 0", x_valid);
    end
    send_weight(3'd2);
    n_checks++;
    if (x !== 7'b0000011 || x_index !== 6'd0) begin
      n_fail++;
      $display("FAIL mid_restart: x=%b idx=%0d required 0000011 0", x, x_index);
    end
    build_model(2);
    collect(0, 0, 100);
    n_checks++;
    if (timed_out || got_x.size() != 21 || got_x[20] !== exp_q[20]) begin
      n_fail++;
      $display("FAIL mid_restart_seq: words=%0d required 21", got_x.size());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      test_sequence(int'($urandom_range(7)), int'($urandom_range(60)), 1'($urandom_range(1)));
      repeat (int'($urandom_range(2))) @(negedge clk);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    rst = 1'b1; y_valid = 1'b0; y = '0; x_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequence(0, 0, 0);
    test_sequence(1, 0, 0);
    test_sequence(3, 0, 0);
    test_back_to_back();
    @(negedge clk);
    test_sequence(2, 40, 1);
    test_reset_mid();
    test_sequence(5, 0, 0);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
